// File: rtl/flapjack_regfile_pkg.sv
// Shared types and helpers for the flapjack multi-port register file.
package flapjack_regfile_pkg;

  typedef enum logic {RF_CLEAR, RF_RUN} rf_state_t;

  localparam int unsigned RF_MAX_NREAD = 4;

  // An index is live when it addresses a real entry that is not the hardwired zero.
  function automatic logic rf_index_live(input int unsigned idx,
                                         input int unsigned count,
                                         input bit          zero_reg);
    return (idx < count) && !(zero_reg && (idx == 0));
  endfunction

endpackage

// File: rtl/flapjack_regfile_clear_seq.sv
// Post-reset clear sequencer: walks every entry once, then raises ready.
module flapjack_regfile_clear_seq
  import flapjack_regfile_pkg::*;
#(
  parameter  int unsigned COUNT = 8,
  localparam int unsigned IW    = $clog2(COUNT)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          clr_we,
  output logic [IW-1:0] clr_index,
  output logic          ready
);

  rf_state_t     state, state_nx;
  logic [IW-1:0] clr_cnt, clr_cnt_nx;
  logic          ready_nx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= RF_CLEAR;
      clr_cnt <= '0;
      ready   <= 1'b0;
    end else begin
      state   <= state_nx;
      clr_cnt <= clr_cnt_nx;
      ready   <= ready_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    clr_cnt_nx = clr_cnt;
    ready_nx   = ready;
    clr_we     = 1'b0;
    clr_index  = clr_cnt;
    case (state)
      RF_CLEAR: begin
        clr_we = 1'b1;
        if (clr_cnt == IW'(COUNT - 1)) begin
          state_nx = RF_RUN;
          ready_nx = 1'b1;
        end else begin
          clr_cnt_nx = clr_cnt + 1'b1;
        end
      end
      RF_RUN: ready_nx = 1'b1;
      default: begin
        state_nx = RF_CLEAR;
        ready_nx = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/flapjack_regfile_mp.sv
// Multi-port register file with busy scoreboard and hardware clear.
// Define FLAPJACK_REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module flapjack_regfile_mp
  import flapjack_regfile_pkg::*;
#(
  parameter  int unsigned           WIDTH     = 16,
  parameter  int unsigned           COUNT     = 8,
  parameter  int unsigned           NREAD     = 2,
  parameter  bit                    ZERO_REG  = 1'b0,
  parameter  logic [WIDTH-1:0]      RESET_VAL = '0,
  localparam int unsigned           IW        = $clog2(COUNT)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREAD*IW-1:0]    rd_index,
  output logic [NREAD*WIDTH-1:0] rd_value,
  input  logic [IW-1:0]          wr_index,
  input  logic [WIDTH-1:0]       wr_value,
  input  logic                   wr_strobe,
  input  logic [IW-1:0]          rsv_index,
  input  logic                   rsv_strobe,
  output logic [COUNT-1:0]       busy,
  output logic                   ready
);

  logic [WIDTH-1:0] regs [0:COUNT-1];
  logic             clr_we;
  logic [IW-1:0]    clr_index;
  logic             wr_ok, rsv_ok;
  logic [COUNT-1:0] busy_nx;

  flapjack_regfile_clear_seq #(.COUNT(COUNT)) u_clear_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_we    (clr_we),
    .clr_index (clr_index),
    .ready     (ready)
  );

  assign wr_ok  = rst_n && ready && wr_strobe
                  && rf_index_live(32'(wr_index), COUNT, ZERO_REG);
  assign rsv_ok = rst_n && ready && rsv_strobe
                  && rf_index_live(32'(rsv_index), COUNT, ZERO_REG);

  always_ff @(posedge clk) begin
    if (clr_we) begin
      regs[clr_index] <= RESET_VAL;
    end else if (wr_ok) begin
      regs[wr_index] <= wr_value;
    end
  end

  // Reservation is applied after the write-clear so a new producer wins.
  always_comb begin
    busy_nx = busy;
    for (int unsigned i = 0; i < COUNT; i++) begin
      if (wr_ok && (32'(wr_index) == i)) busy_nx[i] = 1'b0;
      if (rsv_ok && (32'(rsv_index) == i)) busy_nx[i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= busy_nx;
    end
  end

  for (genvar p = 0; p < NREAD; p++) begin : g_rd
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] rd_nx, rd_q;

    assign idx = rd_index[p*IW +: IW];

    always_comb begin
      rd_nx = '0;
      if (rf_index_live(32'(idx), COUNT, ZERO_REG)) begin
        rd_nx = regs[idx];
`ifdef FLAPJACK_REGFILE_BYPASS_EN
        if (wr_ok && (wr_index == idx)) rd_nx = wr_value;
`endif
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n || !ready) begin
        rd_q <= '0;
      end else begin
        rd_q <= rd_nx;
      end
    end

    assign rd_value[p*WIDTH +: WIDTH] = rd_q;
  end

endmodule

// File: tb/tb_flapjack_regfile_mp.sv
// Scoreboard bench: two register file configurations driven with shared stimulus.
module tb_flapjack_regfile_mp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  rd_index;
  logic [2:0]  wr_index, rsv_index;
  logic [15:0] wr_value;
  logic        wr_strobe, rsv_strobe;
  logic [31:0] rd_value0, rd_value1;
  logic [7:0]  busy0;
  logic [5:0]  busy1;
  logic        ready0, ready1;

  always #5 clk = ~clk;

  flapjack_regfile_mp #(
    .WIDTH(16), .COUNT(8), .NREAD(2), .ZERO_REG(1'b0), .RESET_VAL(16'h0000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rd_index(rd_index), .rd_value(rd_value0),
    .wr_index(wr_index), .wr_value(wr_value), .wr_strobe(wr_strobe),
    .rsv_index(rsv_index), .rsv_strobe(rsv_strobe), .busy(busy0), .ready(ready0)
  );

  flapjack_regfile_mp #(
    .WIDTH(16), .COUNT(6), .NREAD(2), .ZERO_REG(1'b1), .RESET_VAL(16'h5A5A)
  ) dut_z (
    .clk(clk), .rst_n(rst_n), .rd_index(rd_index), .rd_value(rd_value1),
    .wr_index(wr_index), .wr_value(wr_value), .wr_strobe(wr_strobe),
    .rsv_index(rsv_index), .rsv_strobe(rsv_strobe), .busy(busy1), .ready(ready1)
  );

  typedef struct {
    int          due;
    int          inst;
    int          kind;
    logic [15:0] val;
  } exp_t;

  exp_t        sb_q[$];
  int          edge_cnt = 0;
  int          checks   = 0;
  int          passed   = 0;

  // Reference model state, one slot per instance.
  logic [15:0] m_regs [2][8];
  bit          m_busy [2][8];
  int          m_k    [2] = '{0, 0};
  int          m_cnt  [2] = '{8, 6};
  bit          m_zero [2] = '{1'b0, 1'b1};
  logic [15:0] m_rst  [2] = '{16'h0000, 16'h5A5A};

  always @(posedge clk) edge_cnt++;

  function automatic bit live(input int n, input int idx);
    return (idx < m_cnt[n]) && !(m_zero[n] && idx == 0);
  endfunction

  function automatic logic [15:0] model_read(input int n, input int r, input int wi,
                                             input logic [15:0] wv, input logic ws);
    if (!live(n, r)) return 16'h0000;
`ifdef FLAPJACK_REGFILE_BYPASS_EN
    if (ws && live(n, wi) && wi == r) return wv;
`endif
    return m_regs[n][r];
  endfunction

  task automatic model_edge(input int n, input logic rst, input int r0, input int r1,
                            input int wi, input logic [15:0] wv, input logic ws,
                            input int ri, input logic rs);
    logic [15:0] e0, e1, bv;
    e0 = '0;
    e1 = '0;
    if (!rst) begin
      m_k[n] = 0;
      for (int i = 0; i < 8; i++) m_busy[n][i] = 1'b0;
    end else if (m_k[n] >= m_cnt[n]) begin
      e0 = model_read(n, r0, wi, wv, ws);
      e1 = model_read(n, r1, wi, wv, ws);
      if (ws && live(n, wi)) begin
        m_regs[n][wi] = wv;
        m_busy[n][wi] = 1'b0;
      end
      if (rs && live(n, ri)) m_busy[n][ri] = 1'b1;
    end else begin
      m_regs[n][m_k[n]] = m_rst[n];
      m_k[n]++;
    end
    bv = '0;
    for (int i = 0; i < m_cnt[n]; i++) bv[i] = m_busy[n][i];
    sb_q.push_back('{edge_cnt + 1, n, 0, {15'b0, (m_k[n] >= m_cnt[n])}});
    sb_q.push_back('{edge_cnt + 1, n, 1, bv});
    sb_q.push_back('{edge_cnt + 1, n, 2, e0});
    sb_q.push_back('{edge_cnt + 1, n, 3, e1});
  endtask

  task automatic step(input logic rst, input int r0, input int r1, input int wi,
                      input logic [15:0] wv, input logic ws, input int ri, input logic rs);
    rst_n      = rst;
    rd_index   = {3'(r1), 3'(r0)};
    wr_index   = 3'(wi);
    wr_value   = wv;
    wr_strobe  = ws;
    rsv_index  = 3'(ri);
    rsv_strobe = rs;
    for (int n = 0; n < 2; n++) model_edge(n, rst, r0, r1, wi, wv, ws, ri, rs);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cycles);
    for (int c = 0; c < cycles; c++) step(1'b1, 0, 0, 0, 16'h0, 1'b0, 0, 1'b0);
  endtask

  function automatic logic [15:0] actual(input int inst, input int kind);
    if (inst == 0) begin
      case (kind)
        0:       return {15'b0, ready0};
        1:       return {8'b0, busy0};
        2:       return rd_value0[15:0];
        default: return rd_value0[31:16];
      endcase
    end
    case (kind)
      0:       return {15'b0, ready1};
      1:       return {10'b0, busy1};
      2:       return rd_value1[15:0];
      default: return rd_value1[31:16];
    endcase
  endfunction

  string kind_name [4] = '{"ready", "busy", "rd_value0", "rd_value1"};

  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].due <= edge_cnt) begin
      exp_t e;
      logic [15:0] act;
      e   = sb_q.pop_front();
      act = actual(e.inst, e.kind);
      checks++;
      if (act === e.val) passed++;
      else $display("FAIL %s inst%0d edge%0d: got %h expected %h",
                    kind_name[e.kind], e.inst, e.due, act, e.val);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; rd_index = '0; wr_index = '0; wr_value = '0;
    wr_strobe = 1'b0; rsv_index = '0; rsv_strobe = 1'b0;
    @(posedge clk);
    #1;
    // Reset then clear sequence
    step(1'b0, 0, 0, 0, 16'h0, 1'b0, 0, 1'b0);
    idle(9);
    // Write then dual read of same index
    step(1'b1, 0, 0, 3, 16'hBEEF, 1'b1, 0, 1'b0);
    step(1'b1, 3, 3, 0, 16'h0, 1'b0, 0, 1'b0);
    // Same-cycle write/read of index 5
    step(1'b1, 5, 1, 5, 16'h1234, 1'b1, 0, 1'b0);
    step(1'b1, 5, 5, 0, 16'h0, 1'b0, 0, 1'b0);
    // Scoreboard: reserve, write-clear, simultaneous reserve+write
    step(1'b1, 0, 0, 0, 16'h0, 1'b0, 2, 1'b1);
    step(1'b1, 0, 0, 2, 16'h2222, 1'b1, 0, 1'b0);
    step(1'b1, 0, 0, 2, 16'h3333, 1'b1, 2, 1'b1);
    step(1'b1, 2, 2, 0, 16'h0, 1'b0, 2, 1'b1);
    // Entry 0 and out-of-range index 7
    step(1'b1, 0, 0, 0, 16'hFFFF, 1'b1, 0, 1'b0);
    step(1'b1, 0, 0, 0, 16'h0, 1'b0, 0, 1'b1);
    step(1'b1, 0, 7, 7, 16'hCAFE, 1'b1, 7, 1'b1);
    step(1'b1, 7, 0, 0, 16'h0, 1'b0, 6, 1'b1);
    idle(1);
    // Reset mid-clear after busy bits were set
    step(1'b0, 0, 0, 0, 16'h0, 1'b0, 0, 1'b0);
    idle(4);
    step(1'b0, 0, 0, 0, 16'h0, 1'b0, 0, 1'b0);
    idle(9);
    step(1'b1, 3, 4, 0, 16'h0, 1'b0, 0, 1'b0);
    // Randomized traffic with rare resets
    for (int c = 0; c < 600; c++) begin
      int          r0, r1, wi, ri;
      logic        ws, rs, rst;
      logic [15:0] wv;
      wi  = int'($urandom_range(0, 7));
      ri  = int'($urandom_range(0, 7));
      r0  = ($urandom_range(0, 3) == 0) ? wi : int'($urandom_range(0, 7));
      r1  = int'($urandom_range(0, 7));
      wv  = 16'($urandom);
      ws  = ($urandom_range(0, 1) == 1);
      rs  = ($urandom_range(0, 9) < 3);
      rst = ($urandom_range(0, 99) != 0);
      step(rst, r0, r1, wi, wv, ws, ri, rs);
    end
    idle(2);
    @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() == 0) passed++;
    else $display("FAIL drain: got %0d pending expectations, expected 0", sb_q.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
